// File: rtl/uart_pkg.sv
// Types shared by uart_rx and its receive-side buffering.
package uart_pkg;

    typedef logic [7:0] uart_byte_t;

    // Per-byte status that uart_rx raises alongside its data pulse.
    typedef struct packed {
        logic valid;
        logic error;
        logic brk;
    } uart_rx_status_t;

    function automatic logic byte_is_clean(input uart_rx_status_t st);
        return st.valid && !st.error && !st.brk;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Flop-array FIFO with extra-MSB pointers. Flush wins over push and pop.
module sync_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [Width-1:0]         wdata,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AddrWidth = $clog2(Depth);
    localparam logic [AddrWidth:0] PtrOne = 1;

    logic [Width-1:0]     mem [Depth];
    logic [AddrWidth:0]   wr_ptr;
    logic [AddrWidth:0]   rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AddrWidth] != rd_ptr[AddrWidth]) &&
                   (wr_ptr[AddrWidth-1:0] == rd_ptr[AddrWidth-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign do_pop  = pop && !empty && !flush;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrOne;
            if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AddrWidth-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AddrWidth-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: filters framing errors, flushes on break, flags overflow
// rather than back-pressuring uart_rx.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int Depth       = 16,
    parameter int ErrCntWidth = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  uart_byte_t               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_error,
    input  logic                     rx_break,
    output uart_byte_t               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(Depth):0]   count,
    output logic                     overflow,
    output logic                     break_seen,
    output logic [ErrCntWidth-1:0]   error_count,
    input  logic                     clear_flags
);

    localparam logic [ErrCntWidth-1:0] ErrOne = 1;

    uart_rx_status_t rx_status;
    logic            push_req;
    logic            err_byte;
    logic            pop;
    logic            full;
    logic            empty;

    assign rx_status = '{valid: rx_valid, error: rx_error, brk: rx_break};
    assign push_req  = byte_is_clean(rx_status);
    assign err_byte  = rx_valid && rx_error;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !rx_break;

    sync_fifo #(
        .Width (8),
        .Depth (Depth)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (pop),
        .flush (rx_break),
        .wdata (rx_data),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Set events take priority over clear_flags in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow    <= 1'b0;
            break_seen  <= 1'b0;
            error_count <= '0;
        end else begin
            if (push_req && full && !pop) overflow <= 1'b1;
            else if (clear_flags)         overflow <= 1'b0;

            if (rx_break)         break_seen <= 1'b1;
            else if (clear_flags) break_seen <= 1'b0;

            if (err_byte) begin
                if (clear_flags)              error_count <= ErrOne;
                else if (error_count != '1)   error_count <= error_count + ErrOne;
            end else if (clear_flags) begin
                error_count <= '0;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer between `uart_rx` and the byte consumer (command parser / pattern loader). Captures each received byte pulse into a power-of-two FIFO and presents it on a valid/ready stream. Discards framing-error bytes and counts them. Flushes on a line break, and flags overflow instead of stalling, because `uart_rx` cannot be back-pressured.

## Interface
- `Depth`, 16: FIFO capacity in bytes; power of two, ≥ 2.
- `ErrCntWidth`, 8: width of the saturating error counter.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: byte from `uart_rx` `data_out`.
- `rx_valid` in 1: one-cycle pulse from `uart_rx` `data_valid`.
- `rx_error` in 1: framing error, qualified by `rx_valid`.
- `rx_break` in 1: break detected, one-cycle pulse.
- `out_data` out 8: head byte.
- `out_valid` out 1: head byte available.
- `out_ready` in 1: consumer accepts the head byte.
- `count` out $clog2(Depth)+1: bytes currently stored.
- `overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `break_seen` out 1: sticky; a break flushed the FIFO.
- `error_count` out ErrCntWidth: saturating count of framing-error bytes.
- `clear_flags` in 1: clears `overflow`, `break_seen` and `error_count`.

## Operation
- Push: `rx_valid && !rx_error && !rx_break`, and either not full or a pop occurs in the same cycle. The byte is written at `wr_ptr`.
- Pop: `out_valid && out_ready` at the clock edge. `rd_ptr` advances.
- Error byte: `rx_valid && rx_error` → byte not stored; `error_count` increments, saturating at 2^ErrCntWidth−1.
- Overflow: push requested while `count == Depth` and no pop → byte dropped; `overflow` set.
- Break: `rx_break` → FIFO flushed (pointers and `count` to 0) and `break_seen` set.
  - A simultaneous push or pop is ignored.
  - Break wins over everything except reset.
- Flags: `clear_flags` clears all three status outputs. A set event in the same cycle wins over clear; for the counter, the result is 1 if that cycle carried an error.
- Pointers are $clog2(Depth)+1 bits and wrap naturally.
  - Full: MSBs differ, LSBs equal.
  - Empty: pointers equal.
  - `count = wr_ptr − rd_ptr`, modulo 2^($clog2(Depth)+1).
- `out_data = mem[rd_ptr]`, read from flop storage. Its value is don't-care while `out_valid = 0`.
- `out_valid = (count != 0)`.
- No state machine. The block is a pure pointer/flag datapath.

## Timing
- Reset: asynchronous assert, synchronous release.
  - Pointers, `count`, `out_valid`, `overflow`, `break_seen` and `error_count` reset to 0.
  - `out_data` is don't-care; storage is not reset.
- Latency: a push at edge N gives `out_valid = 1` and `out_data` = that byte after edge N (cycle N+1). There is no same-cycle bypass.
- `count` and the flags update on the edge of the causing event. They are visible the following cycle.
- `out_data` must hold stable while `out_valid && !out_ready`. A stable head is guaranteed because pushes never overwrite `rd_ptr`'s entry when not full.
- Full with a simultaneous push and pop: both take effect, `count` stays at `Depth`, and `overflow` does not set.
- Empty with `out_ready` high: no pop, pointers unchanged.
- Reset asserted mid-stream: contents are lost immediately and `out_valid` drops asynchronously.

## Structure
- Shared package `uart_pkg`:
  - `typedef logic [7:0] uart_byte_t`.
  - The `uart_rx` status bundle type, used by both `uart_rx` and this block.
- Sub-module `sync_fifo` (`Width`, `Depth`): flop-array FIFO with push, pop, flush, full, empty and count. It is reusable for a future `uart_tx` front buffer.
- `uart_rx_fifo` wraps `sync_fifo` and adds error filtering, overflow/break/error flags and the clear logic.

## Test plan
- Basic order: push 0x41, 0x42, 0x43 with `out_ready = 0`.
  - Expect `count` = 3 and `out_data` = 0x41.
  - Then hold `out_ready` high: expect 0x41, 0x42, 0x43 in order on consecutive cycles, then `out_valid = 0`.
- Overflow: `Depth = 16`; push 17 bytes (0x00–0x10), no pops.
  - Expect `count` = 16 and `overflow = 1`.
  - Drain: bytes 0x00–0x0F are read; 0x10 is absent.
- Full plus simultaneous push/pop: with the FIFO full and `out_ready = 1`, push 0xAA.
  - Expect `count` stays 16 and `overflow` stays 0.
  - 0xAA is read last.
- Error filtering: send 0x55 with `rx_error = 1`, then 0x66 clean.
  - Expect `count` = 1, `out_data` = 0x66 and `error_count` = 1.
  - With `ErrCntWidth = 2`, five error bytes leave `error_count` = 3.
- Break: with 5 stored bytes, pulse `rx_break` together with `rx_valid` (0x77) and `out_ready`.
  - Expect `count` = 0, `out_valid = 0` and `break_seen = 1`; 0x77 is not stored.
  - `clear_flags` together with a new error byte gives `error_count` = 1, `break_seen` = 0.
- Async reset: assert `rst_n` low mid-cycle with 3 bytes stored.
  - Expect `out_valid = 0` and `count` = 0 before the next edge.
  - After release, the first push gives `out_valid` high after 1 cycle.
